// File: rtl/tile_op_scheduler_if.sv
// Handshake bundle between the tile op scheduler and its neighbours:
// the command side from the layer controller, the per-tile issue side to the
// operand buffers / broadcast unit / PE array, writeback strobes and status.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface tile_op_scheduler_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_mode;
  logic [CNT_W-1:0]  cmd_rows;
  logic [CNT_W-1:0]  cmd_cols;
  logic [ADDR_W-1:0] cmd_a_base;
  logic [ADDR_W-1:0] cmd_b_base;
  logic [ADDR_W-1:0] cmd_o_base;
  logic              iss_valid;
  logic              iss_ready;
  logic [2:0]        iss_mode;
  logic [ADDR_W-1:0] iss_a_addr;
  logic [ADDR_W-1:0] iss_b_addr;
  logic              iss_acc_first;
  logic              iss_acc_last;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       perf_stall;
  logic [31:0]       perf_tiles;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_rows, cmd_cols, cmd_a_base, cmd_b_base, cmd_o_base,
    input  iss_ready,
    output cmd_ready, iss_valid, iss_mode, iss_a_addr, iss_b_addr, iss_acc_first, iss_acc_last,
    output wb_valid, wb_addr, busy, done, err, perf_stall, perf_tiles
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_rows, cmd_cols, cmd_a_base, cmd_b_base, cmd_o_base,
    output iss_ready,
    input  cmd_ready, iss_valid, iss_mode, iss_a_addr, iss_b_addr, iss_acc_first, iss_acc_last,
    input  wb_valid, wb_addr, busy, done, err, perf_stall, perf_tiles
  );
endinterface

// File: rtl/tile_op_scheduler.sv
// Tile op scheduler: latches one op descriptor, walks the R x C tile grid
// (column inner, row outer), issues per-tile operand addresses and MAC
// first/last flags, and emits writeback strobes PIPE_LAT cycles after each
// result-producing issue. Optional macro SCHED_PERF_EN adds stall/tile
// performance counters; without it those outputs are tied to zero.
module tile_op_scheduler #(
  parameter int TILE_SIZE = 4,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 12,
  parameter int PIPE_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  tile_op_scheduler_if.slave sched_if
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // Array geometry and pipeline depth must be at least one.
  if (PIPE_LAT < 1 || TILE_SIZE < 1) begin : g_param_err
    $error("tile_op_scheduler: TILE_SIZE and PIPE_LAT must be >= 1");
  end

  state_t            r_state, w_state_next;
  logic [2:0]        r_mode;
  logic [CNT_W-1:0]  r_rows, r_cols, r_r, r_c;
  logic [ADDR_W-1:0] r_a_base, r_b_base, r_o_base, r_lin;
  logic              r_err, r_done;
  logic [PIPE_LAT-1:0] r_pipe_v, r_pipe_last;
  logic [ADDR_W-1:0] r_pipe_addr [PIPE_LAT];

  logic              w_cmd_ready, w_iss_valid, w_cmd_hs, w_iss_hs;
  logic              w_cmd_degenerate, w_c_last, w_r_last, w_pipe_busy;
  logic [ADDR_W-1:0] w_r_ext, w_c_ext, w_a_addr, w_b_addr, w_wb_addr;
  logic              w_acc_first, w_acc_last;

  assign w_cmd_hs         = sched_if.cmd_valid && w_cmd_ready;
  assign w_iss_hs         = w_iss_valid && sched_if.iss_ready;
  assign w_cmd_degenerate = (sched_if.cmd_rows == '0) || (sched_if.cmd_cols == '0) ||
                            (sched_if.cmd_mode == 3'b111);
  assign w_c_last         = (r_c == r_cols - CNT_W'(1));
  assign w_r_last         = (r_r == r_rows - CNT_W'(1));
  assign w_pipe_busy      = |r_pipe_v;
  assign w_r_ext          = ADDR_W'(r_r);
  assign w_c_ext          = ADDR_W'(r_c);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs; degenerate ops skip straight to DONE.
  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_iss_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (sched_if.cmd_valid) w_state_next = w_cmd_degenerate ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        w_iss_valid = 1'b1;
        if (sched_if.iss_ready && w_r_last && w_c_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (!w_pipe_busy) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Descriptor latch and tile counters; lin tracks r*C+c incrementally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= '0; r_rows <= '0; r_cols <= '0;
      r_a_base <= '0; r_b_base <= '0; r_o_base <= '0;
      r_r <= '0; r_c <= '0; r_lin <= '0; r_err <= 1'b0;
    end else if (w_cmd_hs) begin
      r_mode   <= sched_if.cmd_mode;
      r_rows   <= sched_if.cmd_rows;
      r_cols   <= sched_if.cmd_cols;
      r_a_base <= sched_if.cmd_a_base;
      r_b_base <= sched_if.cmd_b_base;
      r_o_base <= sched_if.cmd_o_base;
      r_r <= '0; r_c <= '0; r_lin <= '0;
      r_err    <= (sched_if.cmd_mode == 3'b111);
    end else if (w_iss_hs) begin
      r_lin <= r_lin + ADDR_W'(1);
      if (w_c_last) begin
        r_c <= '0;
        r_r <= r_r + CNT_W'(1);
      end else begin
        r_c <= r_c + CNT_W'(1);
      end
    end
  end

  // Mode-dependent operand/writeback addressing and MAC reduction flags.
  always_comb begin
    w_a_addr    = r_a_base + r_lin;
    w_b_addr    = r_b_base + r_lin;
    w_wb_addr   = r_o_base + r_lin;
    w_acc_first = 1'b1;
    w_acc_last  = 1'b1;
    if (r_mode == 3'b011) w_a_addr = r_a_base + w_r_ext;
    case (r_mode)
      3'b000, 3'b011: w_b_addr = r_b_base + w_c_ext;
      3'b001:         w_b_addr = r_b_base + w_r_ext;
      default:        w_b_addr = r_b_base + r_lin;
    endcase
    if (r_mode == 3'b000) begin
      w_acc_first = (r_c == '0);
      w_acc_last  = w_c_last;
      w_wb_addr   = r_o_base + w_r_ext;
    end
  end

  // Fixed-latency result pipe; the array never stalls once a tile is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe_v    <= '0;
      r_pipe_last <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_pipe_addr[i] <= '0;
    end else begin
      r_pipe_v[0]    <= w_iss_hs;
      r_pipe_last[0] <= w_acc_last;
      r_pipe_addr[0] <= w_wb_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipe_v[i]    <= r_pipe_v[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  // Completion pulse, registered one cycle behind the DONE state.
  always_ff @(posedge clk) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == S_DONE);
  end

`ifdef SCHED_PERF_EN
  logic [31:0] r_perf_stall, r_perf_tiles;

  // Saturating stall and issued-tile counters, cleared by reset only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_tiles <= '0;
    end else begin
      if (w_iss_valid && !sched_if.iss_ready && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_iss_hs && r_perf_tiles != '1)
        r_perf_tiles <= r_perf_tiles + 32'd1;
    end
  end

  assign sched_if.perf_stall = r_perf_stall;
  assign sched_if.perf_tiles = r_perf_tiles;
`else
  assign sched_if.perf_stall = '0;
  assign sched_if.perf_tiles = '0;
`endif

  assign sched_if.cmd_ready     = w_cmd_ready;
  assign sched_if.iss_valid     = w_iss_valid;
  assign sched_if.iss_mode      = w_iss_valid ? r_mode : 3'b000;
  assign sched_if.iss_a_addr    = w_iss_valid ? w_a_addr : '0;
  assign sched_if.iss_b_addr    = w_iss_valid ? w_b_addr : '0;
  assign sched_if.iss_acc_first = w_iss_valid && w_acc_first;
  assign sched_if.iss_acc_last  = w_iss_valid && w_acc_last;
  assign sched_if.wb_valid      = r_pipe_v[PIPE_LAT-1] && r_pipe_last[PIPE_LAT-1];
  assign sched_if.wb_addr       = sched_if.wb_valid ? r_pipe_addr[PIPE_LAT-1] : '0;
  assign sched_if.busy          = (r_state != S_IDLE);
  assign sched_if.done          = r_done;
  assign sched_if.err           = r_err;

endmodule

// File: tb/tb_tile_op_scheduler.sv
// Directed bench for tile_op_scheduler: runs hand-computed ops, logs every
// handshake/strobe at the falling edge and compares against fixed tables.
module tb_tile_op_scheduler;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_op_scheduler_if #(.CNT_W(8), .ADDR_W(12)) bus ();

  tile_op_scheduler #(.TILE_SIZE(4), .CNT_W(8), .ADDR_W(12), .PIPE_LAT(LAT)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_if (bus.slave)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        f;
    logic        l;
    logic [2:0]  mode;
  } iss_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_q[$], iss_cyc_q[$], wb_cyc_q[$], done_q[$];
  iss_t iss_q[$];
  logic [11:0] wb_q[$];
  int stall_cnt = 0;
  logic prev_stall = 1'b0;
  iss_t prev_iss;

  logic [11:0] exp_a[$], exp_b[$], exp_wb[$];
  bit exp_f[$], exp_l[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction log, sampled mid-cycle.
  always @(negedge clk) begin
    iss_t cur;
    cur = '{a: bus.iss_a_addr, b: bus.iss_b_addr, f: bus.iss_acc_first,
            l: bus.iss_acc_last, mode: bus.iss_mode};
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_q.push_back(cyc);
      $display("[%0d] cmd accepted mode=%0d", cyc, bus.cmd_mode);
    end
    if (bus.iss_valid) begin
      if (prev_stall) check_eq($sformatf("stall_hold_c%0d", cyc), 32'(cur), 32'(prev_iss));
      if (bus.iss_ready) begin
        iss_q.push_back(cur);
        iss_cyc_q.push_back(cyc);
        $display("[%0d] issue a=%0h b=%0h first=%0b last=%0b", cyc, cur.a, cur.b, cur.f, cur.l);
      end else begin
        stall_cnt++;
      end
      prev_stall = !bus.iss_ready;
      prev_iss   = cur;
    end else begin
      prev_stall = 1'b0;
    end
    if (bus.wb_valid) begin
      wb_q.push_back(bus.wb_addr);
      wb_cyc_q.push_back(cyc);
      $display("[%0d] writeback addr=%0h", cyc, bus.wb_addr);
    end
    if (bus.done) begin
      done_q.push_back(cyc);
      $display("[%0d] done", cyc);
    end
  end

  task automatic clear_logs();
    acc_q.delete(); iss_q.delete(); iss_cyc_q.delete();
    wb_q.delete(); wb_cyc_q.delete(); done_q.delete();
    stall_cnt = 0;
  endtask

  task automatic drive_cmd(input logic [2:0] mode, input logic [7:0] rows, input logic [7:0] cols,
                           input logic [11:0] a, input logic [11:0] b, input logic [11:0] o);
    bus.cmd_mode = mode; bus.cmd_rows = rows; bus.cmd_cols = cols;
    bus.cmd_a_base = a; bus.cmd_b_base = b; bus.cmd_o_base = o;
    bus.cmd_valid = 1'b1;
  endtask

  // One op from IDLE; alt=1 drives iss_ready 1,0,1,0... from the first issue cycle.
  task automatic run_op(input logic [2:0] mode, input logic [7:0] rows, input logic [7:0] cols,
                        input logic [11:0] a, input logic [11:0] b, input logic [11:0] o,
                        input bit alt);
    int k = 0, guard = 0, tail = 0;
    clear_logs();
    @(posedge clk); #1;
    drive_cmd(mode, rows, cols, a, b, o);
    bus.iss_ready = 1'b1;
    while (guard < 300 && tail < 5) begin
      @(posedge clk); #1;
      guard++;
      if (acc_q.size() > 0) begin
        bus.cmd_valid = 1'b0;
        bus.iss_ready = alt ? (k % 2 == 0) : 1'b1;
        k++;
      end
      if (done_q.size() > 0) tail++;
    end
    bus.iss_ready = 1'b1;
  endtask

  // Compares the logged issues/writebacks of the last op with the exp_* tables.
  task automatic verify(input string tn, input int exp_done);
    int j = 0;
    check_eq({tn, "_n_iss"}, iss_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < iss_q.size(); i++) begin
      check_eq($sformatf("%s_a%0d", tn, i), 32'(iss_q[i].a), 32'(exp_a[i]));
      check_eq($sformatf("%s_b%0d", tn, i), 32'(iss_q[i].b), 32'(exp_b[i]));
      check_eq($sformatf("%s_first%0d", tn, i), 32'(iss_q[i].f), 32'(exp_f[i]));
      check_eq($sformatf("%s_last%0d", tn, i), 32'(iss_q[i].l), 32'(exp_l[i]));
    end
    check_eq({tn, "_n_wb"}, wb_q.size(), exp_wb.size());
    for (int i = 0; i < exp_a.size() && i < iss_q.size(); i++) begin
      if (exp_l[i] && j < wb_q.size() && j < exp_wb.size()) begin
        check_eq($sformatf("%s_wb_addr%0d", tn, j), 32'(wb_q[j]), 32'(exp_wb[j]));
        check_eq($sformatf("%s_wb_lat%0d", tn, j), 32'(wb_cyc_q[j] - iss_cyc_q[i]), LAT);
        j++;
      end
    end
    check_eq({tn, "_n_done"}, done_q.size(), exp_done);
    if (done_q.size() > 0 && wb_cyc_q.size() > 0)
      check_eq({tn, "_done_not_before_wb"}, 32'(done_q[done_q.size()-1] >= wb_cyc_q[wb_cyc_q.size()-1]), 1);
  endtask

  initial begin
    int guard;
    bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_rows = '0; bus.cmd_cols = '0;
    bus.cmd_a_base = '0; bus.cmd_b_base = '0; bus.cmd_o_base = '0; bus.iss_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check_eq("rst_iss_valid", 32'(bus.iss_valid), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_err", 32'(bus.err), 0);
    check_eq("rst_wb_valid", 32'(bus.wb_valid), 0);
    check_eq("rst_perf_tiles", bus.perf_tiles, 0);

    // MAC R=2 C=3
    run_op(3'b000, 8'd2, 8'd3, 12'h010, 12'h040, 12'h080, 1'b0);
    exp_a = '{12'h10, 12'h11, 12'h12, 12'h13, 12'h14, 12'h15};
    exp_b = '{12'h40, 12'h41, 12'h42, 12'h40, 12'h41, 12'h42};
    exp_f = '{1, 0, 0, 1, 0, 0};
    exp_l = '{0, 0, 1, 0, 0, 1};
    exp_wb = '{12'h80, 12'h81};
    verify("mac", 1);

    // Outer product R=2 C=2
    run_op(3'b011, 8'd2, 8'd2, 12'h000, 12'h000, 12'h000, 1'b0);
    exp_a = '{12'h0, 12'h0, 12'h1, 12'h1};
    exp_b = '{12'h0, 12'h1, 12'h0, 12'h1};
    exp_f = '{1, 1, 1, 1};
    exp_l = '{1, 1, 1, 1};
    exp_wb = '{12'h0, 12'h1, 12'h2, 12'h3};
    verify("outer", 1);

    // EWA-mat R=1 C=4 with alternating iss_ready
    run_op(3'b101, 8'd1, 8'd4, 12'h100, 12'h200, 12'h300, 1'b1);
    exp_a = '{12'h100, 12'h101, 12'h102, 12'h103};
    exp_b = '{12'h200, 12'h201, 12'h202, 12'h203};
    exp_f = '{1, 1, 1, 1};
    exp_l = '{1, 1, 1, 1};
    exp_wb = '{12'h300, 12'h301, 12'h302, 12'h303};
    verify("ewa_stall", 1);
    check_eq("ewa_stall_cycles", stall_cnt, 3);
`ifdef SCHED_PERF_EN
    check_eq("perf_stall", bus.perf_stall, 3);
    check_eq("perf_tiles", bus.perf_tiles, 14);
`else
    check_eq("perf_stall_tied", bus.perf_stall, 0);
    check_eq("perf_tiles_tied", bus.perf_tiles, 0);
`endif

    // Illegal mode: no issues, sticky err
    run_op(3'b111, 8'd1, 8'd1, 12'h0, 12'h0, 12'h0, 1'b0);
    exp_a.delete(); exp_b.delete(); exp_f.delete(); exp_l.delete(); exp_wb.delete();
    verify("mode111", 1);
    check_eq("mode111_err", 32'(bus.err), 1);

    // R=0: done two cycles after accept, err cleared by this accept
    run_op(3'b000, 8'd0, 8'd5, 12'h0, 12'h0, 12'h0, 1'b0);
    verify("rows0", 1);
    if (acc_q.size() > 0 && done_q.size() > 0)
      check_eq("rows0_done_delay", 32'(done_q[0] - acc_q[0]), 2);
    check_eq("rows0_err_clear", 32'(bus.err), 0);

    // Reset in the middle of a MAC op, third tile handshaking as reset lands
    clear_logs();
    @(posedge clk); #1;
    drive_cmd(3'b000, 8'd2, 8'd3, 12'h010, 12'h040, 12'h080);
    guard = 0;
    while (guard < 50 && iss_q.size() < 2) begin
      @(posedge clk); #1;
      guard++;
      if (acc_q.size() > 0) bus.cmd_valid = 1'b0;
    end
    check_eq("midrst_two_tiles", iss_q.size(), 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_iss_valid", 32'(bus.iss_valid), 0);
    check_eq("midrst_wb_valid", 32'(bus.wb_valid), 0);
    check_eq("midrst_busy", 32'(bus.busy), 0);
    check_eq("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    check_eq("midrst_perf_tiles", bus.perf_tiles, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wb_q.delete(); wb_cyc_q.delete();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_no_late_wb", wb_q.size(), 0);
    check_eq("midrst_idle_busy", 32'(bus.busy), 0);

    // cmd_valid held high across two back-to-back ops
    clear_logs();
    @(posedge clk); #1;
    drive_cmd(3'b010, 8'd1, 8'd2, 12'h000, 12'h020, 12'h040);
    guard = 0;
    begin
      int tail = 0;
      while (guard < 300 && tail < 5) begin
        @(posedge clk); #1;
        guard++;
        if (acc_q.size() == 1) drive_cmd(3'b100, 8'd1, 8'd1, 12'h005, 12'h006, 12'h007);
        if (acc_q.size() >= 2) bus.cmd_valid = 1'b0;
        if (done_q.size() >= 2) tail++;
      end
    end
    exp_a = '{12'h000, 12'h001, 12'h005};
    exp_b = '{12'h020, 12'h021, 12'h006};
    exp_f = '{1, 1, 1};
    exp_l = '{1, 1, 1};
    exp_wb = '{12'h040, 12'h041, 12'h007};
    verify("b2b", 2);
    check_eq("b2b_n_accept", acc_q.size(), 2);
    if (acc_q.size() >= 2 && done_q.size() >= 1)
      check_eq("b2b_accept_after_done", 32'(acc_q[1] >= done_q[0]), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
